// File: rtl/ov5640_pwr_seq.sv
// OV5640 power sequencer: timed PWDN/RESETB/XCLK bring-up, controlled shutdown,
// restart, and an SCCB-configuration watchdog with bounded power-cycle retries.
module ov5640_pwr_seq #(
  parameter int CNT_W     = 21,
  parameter int T_OFF     = 50_000,
  parameter int T_PWDN    = 300_000,
  parameter int T_RST     = 100_000,
  parameter int T_SETTLE  = 1_050_000,
  parameter int T_CFG     = 1_000_000,
  parameter int MAX_RETRY = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pwr_en,
  input  logic       restart,
  input  logic       cfg_done,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       xclk_en,
  output logic       power_done,
  output logic       cam_ready,
  output logic       cfg_err,
  output logic [2:0] seq_state
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] CFG_LAST    = CNT_W'(T_CFG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWDN   = 3'd1,
    S_RST    = 3'd2,
    S_SETTLE = 3'd3,
    S_CFG    = 3'd4,
    S_READY  = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  // {pwdn, rst_n, xclk_en, power_done, cam_ready, cfg_err}
  logic [5:0]       out_q, out_d;
  logic             abort;
  logic             restart_ok;

  assign abort      = (state_q != S_OFF) && !pwr_en;
  assign restart_ok = restart && (state_q inside {S_PWDN, S_RST, S_SETTLE, S_CFG, S_READY});

  // State register, delay counter, retry counter and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= 6'b100000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic, ordered by transition priority
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (abort) begin
      state_d = S_OFF;
      retry_d = '0;
    end else if (restart_ok) begin
      state_d = S_OFF;
    end else begin
      unique case (state_q)
        S_OFF:    if (pwr_en && cnt_q == OFF_LAST) state_d = S_PWDN;
        S_PWDN:   if (cnt_q == PWDN_LAST)          state_d = S_RST;
        S_RST:    if (cnt_q == RST_LAST)           state_d = S_SETTLE;
        S_SETTLE: if (cnt_q == SETTLE_LAST)        state_d = S_CFG;
        S_CFG: begin
          if (cfg_done) begin
            state_d = S_READY;
            retry_d = '0;
          end else if (cnt_q == CFG_LAST) begin
            if (32'(retry_q) < MAX_RETRY) begin
              state_d = S_OFF;
              retry_d = retry_q + RW'(1);
            end else begin
              state_d = S_ERROR;
            end
          end
        end
        S_READY:  state_d = S_READY;
        S_ERROR:  state_d = S_ERROR;
        default:  state_d = S_OFF;
      endcase
    end
  end

  // OFF saturates at its exit value so a late pwr_en leaves at once
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_OFF) begin
      if (cnt_q != OFF_LAST) cnt_d = cnt_q + CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode from next state so pins move on the same edge as seq_state
  always_comb begin
    out_d = 6'b100000;
    unique case (state_d)
      S_OFF:    out_d = 6'b100000;
      S_PWDN:   out_d = 6'b101000;
      S_RST:    out_d = 6'b001000;
      S_SETTLE: out_d = 6'b011000;
      S_CFG:    out_d = 6'b011100;
      S_READY:  out_d = 6'b011110;
      S_ERROR:  out_d = 6'b100001;
      default:  out_d = 6'b100000;
    endcase
  end

  assign cam_pwdn   = out_q[5];
  assign cam_rst_n  = out_q[4];
  assign xclk_en    = out_q[3];
  assign power_done = out_q[2];
  assign cam_ready  = out_q[1];
  assign cfg_err    = out_q[0];
  assign seq_state  = state_q;

endmodule

// File: tb/tb_ov5640_pwr_seq.sv
// Scoreboard bench for ov5640_pwr_seq: directed scenarios then random stimulus,
// each edge checked against a time-in-state reference model.
module tb_ov5640_pwr_seq;
  localparam int T_OFF = 4, T_PWDN = 6, T_RST = 3, T_SETTLE = 5, T_CFG = 10, MAX_RETRY = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       pwr_en = 1'b0, restart = 1'b0, cfg_done = 1'b0;
  logic       cam_pwdn, cam_rst_n, xclk_en, power_done, cam_ready, cfg_err;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  ov5640_pwr_seq #(
    .CNT_W(21), .T_OFF(T_OFF), .T_PWDN(T_PWDN), .T_RST(T_RST),
    .T_SETTLE(T_SETTLE), .T_CFG(T_CFG), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pwr_en(pwr_en), .restart(restart),
    .cfg_done(cfg_done), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .xclk_en(xclk_en), .power_done(power_done), .cam_ready(cam_ready),
    .cfg_err(cfg_err), .seq_state(seq_state)
  );

  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] r;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: current phase and how many whole cycles it has lasted
  int m_st = 0, m_el = 0, m_retry = 0;

  function automatic logic [5:0] pins(input int st);
    case (st)
      0: return 6'b100000;
      1: return 6'b101000;
      2: return 6'b001000;
      3: return 6'b011000;
      4: return 6'b011100;
      5: return 6'b011110;
      6: return 6'b100001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int dur(input int st);
    case (st)
      0: return T_OFF;
      1: return T_PWDN;
      2: return T_RST;
      3: return T_SETTLE;
      default: return T_CFG;
    endcase
  endfunction

  task automatic m_step(input bit rst, input bit en, input bit rs, input bit cd);
    int nx;
    nx = m_st;
    if (rst) begin
      m_st = 0; m_el = 0; m_retry = 0;
    end else begin
      if (m_st != 0 && !en) begin
        nx = 0; m_retry = 0;
      end else if (rs && m_st >= 1 && m_st <= 5) begin
        nx = 0;
      end else if (m_st == 4 && cd) begin
        nx = 5; m_retry = 0;
      end else if (m_st == 4 && m_el == T_CFG - 1) begin
        if (m_retry < MAX_RETRY) begin
          m_retry++; nx = 0;
        end else begin
          nx = 6;
        end
      end else if (m_st <= 3 && m_el >= dur(m_st) - 1 && (m_st != 0 || en)) begin
        nx = m_st + 1;
      end
      m_el = (nx != m_st) ? 0 : m_el + 1;
      m_st = nx;
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs (just after a negedge), predict, wait to next negedge
  task automatic cyc(input bit rst, input bit en, input bit rs, input bit cd);
    exp_t e;
    sys_rst = rst; pwr_en = en; restart = rs; cfg_done = cd;
    m_step(rst, en, rs, cd);
    e.o = {3'(m_st), pins(m_st)};
    e.r = 32'(m_retry);
    sb_q.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic run_until(input int st, input int el, input bit cd);
    int n;
    n = 0;
    while (!(m_st == st && m_el == el) && n < 200) begin
      cyc(1'b0, 1'b1, 1'b0, cd);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL run_until timeout actual_state=%0d required_state=%0d", m_st, st);
    end
  endtask

  // Monitor: event edges for the power-up timing and scoreboard comparison
  int   edge_n = 0, pd_cnt = 0;
  int   ev_x = -1, ev_p = -1, ev_r = -1, ev_pd = -1, ev_cr = -1;
  logic p_x = 0, p_p = 1, p_r = 0, p_pd = 0, p_cr = 0;

  initial begin
    exp_t e;
    logic rst_s;
    forever begin
      @(posedge sys_clk);
      rst_s = sys_rst;
      #1;
      if (rst_s) begin
        edge_n = 0;
        ev_x = -1; ev_p = -1; ev_r = -1; ev_pd = -1; ev_cr = -1;
      end else begin
        edge_n++;
        if (!p_x && xclk_en && ev_x < 0)       ev_x  = edge_n;
        if (p_p && !cam_pwdn && ev_p < 0)      ev_p  = edge_n;
        if (!p_r && cam_rst_n && ev_r < 0)     ev_r  = edge_n;
        if (!p_pd && power_done && ev_pd < 0)  ev_pd = edge_n;
        if (!p_cr && cam_ready && ev_cr < 0)   ev_cr = edge_n;
      end
      if (power_done) pd_cnt++;
      p_x = xclk_en; p_p = cam_pwdn; p_r = cam_rst_n; p_pd = power_done; p_cr = cam_ready;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({seq_state, cam_pwdn, cam_rst_n, xclk_en, power_done, cam_ready, cfg_err} !== e.o
            || 32'(dut.retry_q) != e.r) begin
          errors++;
          $display("FAIL scoreboard t=%0t actual=%b retry=%0d required=%b retry=%0d",
                   $time, {seq_state, cam_pwdn, cam_rst_n, xclk_en, power_done, cam_ready, cfg_err},
                   dut.retry_q, e.o, e.r);
        end
      end
    end
  end

  initial begin
    bit r, en, rs, cd;
    int bias;
    @(negedge sys_clk);

    // Nominal power-up
    cyc(1, 0, 0, 0);
    chk("reset_outputs", int'({seq_state, cam_pwdn, cam_rst_n, xclk_en, power_done, cam_ready, cfg_err}),
        int'(9'b000_100000));
    cyc(1, 1, 0, 0);
    for (int e = 1; e <= 24; e++) cyc(0, 1, 0, e >= 21);
    chk("xclk_rise_edge", ev_x, 4);
    chk("pwdn_fall_edge", ev_p, 10);
    chk("rstn_rise_edge", ev_r, 13);
    chk("power_done_rise_edge", ev_pd, 18);
    chk("cam_ready_rise_edge", ev_cr, 21);

    // Watchdog retries into ERROR
    cyc(0, 0, 0, 0);
    pd_cnt = 0;
    for (int i = 0; i < 100; i++) cyc(0, 1, 0, 0);
    chk("cfg_window_cycles", pd_cnt, 3 * T_CFG);
    chk("error_state", int'(seq_state), 6);
    chk("error_cfg_err", int'(cfg_err), 1);
    chk("error_pwdn", int'(cam_pwdn), 1);
    cyc(0, 1, 1, 0);
    chk("error_ignores_restart", int'(seq_state), 6);
    cyc(0, 0, 0, 0);
    chk("error_cleared", int'(cfg_err), 0);

    // Shutdown in SETTLE cycle 2, pwr_en back one cycle later
    run_until(3, 1, 0);
    cyc(0, 0, 0, 0);
    chk("abort_pwdn", int'(cam_pwdn), 1);
    chk("abort_rstn", int'(cam_rst_n), 0);
    chk("abort_xclk", int'(xclk_en), 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);

    // Restart keeps retry count; restart from READY re-sequences
    run_until(4, 9, 0);
    cyc(0, 1, 0, 0);
    run_until(4, 3, 0);
    cyc(0, 1, 1, 0);
    chk("restart_retry_kept", int'(dut.retry_q), 1);
    run_until(4, 2, 0);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("ready_holds_after_cfg_drop", int'(cam_ready), 1);
    cyc(0, 1, 1, 0);
    chk("restart_ready_low", int'(cam_ready), 0);
    chk("restart_power_done_low", int'(power_done), 0);
    chk("restart_pwdn_high", int'(cam_pwdn), 1);
    for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);

    // Synchronous reset in RST
    run_until(2, 1, 0);
    cyc(1, 1, 0, 0);
    chk("midrst_outputs", int'({seq_state, cam_pwdn, cam_rst_n, xclk_en, power_done, cam_ready, cfg_err}),
        int'(9'b000_100000));
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0);

    // cfg_done coincides with watchdog expiry after one retry
    run_until(4, 9, 0);
    cyc(0, 1, 0, 0);
    run_until(4, 9, 0);
    cyc(0, 1, 0, 1);
    chk("coincide_state", int'(seq_state), 5);
    chk("coincide_retry", int'(dut.retry_q), 0);
    chk("coincide_cfg_err", int'(cfg_err), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bias = (i / 500) % 3;
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 99) < 97);
      rs = ($urandom_range(0, 99) < 2);
      cd = (bias == 0) ? 1'b0 : (bias == 1) ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 1) == 1);
      cyc(r, en, rs, cd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov5640_pwr_seq.md
# ov5640_pwr_seq

Parametrised power-up/power-down sequencer for the OV5640 camera. It replaces the fixed 6 ms / 2 ms / 21 ms counters in the camera top level with a single state machine. On top of that sequence it adds:
- controlled shutdown, with a minimum off time;
- a restart request;
- an SCCB-configuration watchdog with bounded automatic power-cycle retries.

It sits between the board clock/reset and the camera pins. Its `power_done` drives the reset of `ov5640_top`, and its `cam_ready` gates `sys_init_done`.

## Interface
- `CNT_W`, 21: width of the shared delay counter; every `T_*` must be in 1..2^CNT_W.
- `T_OFF`, 50_000: minimum cycles in OFF (PWDN high, XCLK stopped) before any power-up.
- `T_PWDN`, 300_000: cycles with PWDN high and XCLK running.
- `T_RST`, 100_000: cycles with PWDN low and RESETB low.
- `T_SETTLE`, 1_050_000: cycles after reset release before SCCB access is allowed.
- `T_CFG`, 1_000_000: SCCB configuration watchdog, in cycles.
- `MAX_RETRY`, 2: automatic power cycles after a watchdog expiry (0 = no retry).
- `sys_clk` input, 1 bit: single clock for all logic.
- `sys_rst` input, 1 bit: reset, synchronous, active-high.
- `pwr_en` input, 1 bit: level. 1 = camera requested on; 0 = shut down.
- `restart` input, 1 bit: single-cycle pulse that forces a full re-sequence.
- `cfg_done` input, 1 bit: level from the SCCB configurator, synchronous to `sys_clk`.
- `cam_pwdn` output, 1 bit: to the OV5640 PWDN pin.
- `cam_rst_n` output, 1 bit: to the OV5640 RESETB pin.
- `xclk_en` output, 1 bit: enable for the XCLK output gate.
- `power_done` output, 1 bit: active-low reset release for the SCCB configurator.
- `cam_ready` output, 1 bit: camera powered and configured.
- `cfg_err` output, 1 bit: retries exhausted.
- `seq_state` output, 3 bits: current state encoding, for debug.

## Operation
States, with encoding and outputs given as (pwdn, rst_n, xclk_en, power_done, cam_ready, cfg_err):
- **OFF (0)**, outputs (1,0,0,0,0,0).
  - The counter counts up and saturates at T_OFF-1.
  - Go to PWDN when `pwr_en`=1 and counter = T_OFF-1.
- **PWDN (1)**, outputs (1,0,1,0,0,0).
  - Go to RST after T_PWDN cycles.
- **RST (2)**, outputs (0,0,1,0,0,0).
  - Go to SETTLE after T_RST cycles.
- **SETTLE (3)**, outputs (0,1,1,0,0,0).
  - Go to CFG after T_SETTLE cycles.
- **CFG (4)**, outputs (0,1,1,1,0,0).
  - Go to READY when `cfg_done`=1.
  - On watchdog expiry (T_CFG cycles in CFG without `cfg_done`):
    - if retry_cnt < MAX_RETRY, increment retry_cnt and go to OFF;
    - otherwise go to ERROR.
- **READY (5)**, outputs (0,1,1,1,1,0).
  - Remains until it is aborted (see transition priority below).
  - A later drop of `cfg_done` is ignored.
- **ERROR (6)**, outputs (1,0,0,0,0,1).
  - Left only when `pwr_en`=0, to OFF.
  - `restart` is ignored here.

Counter rules:
- The counter is cleared on every state entry. "After N cycles" means the state occupies exactly N clock cycles, with the exit taken when counter = N-1.
- The counter never wraps.
- retry_cnt has width clog2(MAX_RETRY+1), minimum 1 bit. It is cleared on `sys_rst`, on entering READY, and on any `pwr_en`=0 abort. It is not cleared by a watchdog-driven OFF.

Transition priority, highest first:
1. `sys_rst`
2. `pwr_en`=0 in states 1–6 → OFF
3. `restart`=1 in states 1–5 → OFF (retry_cnt kept)
4. `cfg_done` → READY
5. watchdog expiry
6. timed exits

Boundary conditions:
- `cfg_done` and watchdog expiry in the same cycle → READY.
- `restart` while in OFF is ignored.
- `pwr_en` toggling inside OFF does not restart the off timer; T_OFF is always measured from OFF entry.

## Timing
- All outputs are registered and decoded from next-state, so they change on the same edge as `seq_state`, with no combinational path from inputs.
- Reset values: `seq_state`=0, `cam_pwdn`=1, `cam_rst_n`=0, `xclk_en`=0, `power_done`=0, `cam_ready`=0, `cfg_err`=0, counter=0, retry_cnt=0.
- Abort latency: one edge. The cycle after `pwr_en` is sampled low, `cam_pwdn`=1, `cam_rst_n`=0 and `xclk_en`=0.
- Nominal power-up, edge-counted from reset release with `pwr_en` held 1: `cam_pwdn` falls at T_OFF+T_PWDN; `cam_rst_n` rises at +T_RST; `power_done` rises at +T_SETTLE.

## Test plan
Bench parameters: T_OFF=4, T_PWDN=6, T_RST=3, T_SETTLE=5, T_CFG=10, MAX_RETRY=2.

1. Nominal power-up: release `sys_rst` with `pwr_en`=1, assert `cfg_done` 2 cycles after `power_done` rises. Required: `xclk_en` rises at edge 4, `cam_pwdn` falls at 10, `cam_rst_n` rises at 13, `power_done` rises at 18, `cam_ready` rises at 21.
2. Watchdog retries: `cfg_done` held 0. Required: three CFG windows of 10 cycles each, separated by full OFF/PWDN/RST/SETTLE sequences; then `seq_state`=6 and `cfg_err`=1 with PWDN high; `pwr_en`=0 then brings `cfg_err` to 0 one edge later.
3. Shutdown in SETTLE: drop `pwr_en` on SETTLE cycle 2, reassert it 1 cycle later. Required: OFF entered on the next edge; PWDN restarts exactly 4 cycles after OFF entry.
4. Restart from READY: pulse `restart` for 1 cycle. Required: `cam_ready` and `power_done` go to 0 and `cam_pwdn` to 1 on the next edge, followed by a full re-sequence with retry_cnt unchanged.
5. Synchronous reset mid-RST, with `sys_rst` high for 1 cycle. Required: all outputs at their reset values on the next edge; the sequence restarts from OFF with a full T_OFF.
6. `cfg_done` and watchdog expiry coincide on CFG cycle 10. Required: `seq_state`=5, retry_cnt=0, `cfg_err`=0.
